// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch path.
//   fetch_state_t : fetch controller states (IDLE, REFILL)
//   NOP           : instruction word presented to the core while stalled
//   offset_w / index_w / tag_w : address field widths derived from the cache geometry
package mips_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic int offset_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    // Bits [1:0] are the byte offset and are never stored.
    function automatic int tag_w(input int lines, input int words_per_line);
        return 30 - $clog2(lines) - $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Storage for the direct-mapped instruction cache: per-line valid bit, tag
// and data words. Writes are synchronous, reads are asynchronous.
//   clk        : clock
//   clear_all  : invalidate every line on the next edge (beats wr_line_en)
//   rd_index / rd_offset : read address; rd_valid, rd_tag, rd_data returned
//   wr_index / wr_offset / wr_data_en / wr_data : single data word write
//   wr_line_en / wr_tag  : commit a line (write tag, set valid)
module icache_array
    import mips_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = index_w(LINES),
    parameter int OFF_W          = offset_w(WORDS_PER_LINE),
    parameter int TAG_W          = tag_w(LINES, WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             clear_all,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFF_W-1:0] rd_offset,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFF_W-1:0] wr_offset,
    input  logic             wr_data_en,
    input  logic [31:0]      wr_data,
    input  logic             wr_line_en,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES*WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (clear_all) begin
            valid <= '0;
        end else if (wr_line_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data are never reset; a line is only trusted through its valid bit.
    always_ff @(posedge clk) begin
        if (wr_line_en) begin
            tags[wr_index] <= wr_tag;
        end
        if (wr_data_en) begin
            data[{wr_index, wr_offset}] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[{rd_index, rd_offset}];

endmodule

// File: rtl/instr_fetch_cache.sv
// Direct-mapped read-only instruction cache. Hits return the instruction in
// the same cycle; a miss stalls the core and refills the whole line from
// backing memory through a req/ack handshake.
//   clk, reset         : clock, synchronous active-high reset
//   pc                 : fetch address
//   flush              : invalidate all lines / abort an ongoing refill
//   instr, stall       : instruction to the core, 1 = instr not valid
//   mem_req, mem_addr  : refill read request and word-aligned address
//   mem_ack, mem_rdata : refill data strobe and data word
module instr_fetch_cache
    import mips_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W  = offset_w(WORDS_PER_LINE);
    localparam int IDX_W  = index_w(LINES);
    localparam int TAG_W  = tag_w(LINES, WORDS_PER_LINE);
    localparam int LINE_W = 30 - OFF_W;   // index + tag: identifies a line
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [OFF_W-1:0] ONE_WORD  = OFF_W'(1);

    fetch_state_t      state;
    logic [LINE_W-1:0] miss_line;
    logic [OFF_W-1:0]  count;

    logic [OFF_W-1:0]  pc_offset;
    logic [IDX_W-1:0]  pc_index;
    logic [TAG_W-1:0]  pc_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;
    logic              hit;
    logic              xfer;
    logic              last_xfer;
    logic              unused_pc;

    assign pc_offset = pc[2 +: OFF_W];
    assign pc_index  = pc[2 + OFF_W +: IDX_W];
    assign pc_tag    = pc[31 -: TAG_W];
    assign unused_pc = ^pc[1:0];

    icache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk        (clk),
        .clear_all  (reset || flush),
        .rd_index   (pc_index),
        .rd_offset  (pc_offset),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_index   (miss_line[IDX_W-1:0]),
        .wr_offset  (count),
        .wr_data_en (xfer),
        .wr_data    (mem_rdata),
        .wr_line_en (last_xfer && !flush),
        .wr_tag     (miss_line[LINE_W-1:IDX_W])
    );

    assign hit       = (state == IDLE) && rd_valid && (rd_tag == pc_tag);
    assign xfer      = (state == REFILL) && mem_ack;
    assign last_xfer = xfer && (count == LAST_WORD);

    assign stall    = !hit;
    assign instr    = hit ? rd_data : NOP;
    assign mem_req  = (state == REFILL);
    assign mem_addr = (state == REFILL) ? {miss_line, count, 2'b00} : 32'h0;

    // Data words written during an aborted refill are harmless: flush also
    // clears every valid bit, so the partial line can never be hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            miss_line <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        miss_line <= pc[31:2 + OFF_W];
                        count     <= '0;
                        state     <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        count <= count + ONE_WORD;
                        if (count == LAST_WORD) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_cache.sv
module tb_instr_fetch_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Backing memory: every word holds its own address.
    assign mem_rdata = mem_addr;

    always #5 clk = ~clk;

    instr_fetch_cache #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .flush     (flush),
        .instr     (instr),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // Reference model: which line address each index holds, plus the refill
    // in progress (line base and how many words have arrived).
    bit          m_valid [16];
    logic [31:0] m_line  [16];
    bit          m_busy;
    logic [31:0] m_base;
    int          m_words;
    bit          m_known = 0;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'hF;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 4) & 32'hF);
    endfunction

    function automatic bit m_hit(input logic [31:0] p);
        return !m_busy && m_valid[idx_of(p)] && (m_line[idx_of(p)] == line_of(p));
    endfunction

    function automatic void m_update(input bit r, input bit f, input logic [31:0] p, input bit a);
        if (r || f) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            m_busy = 0;
            if (r) m_known = 1;
        end else if (m_busy) begin
            if (a) begin
                m_words++;
                if (m_words == 4) begin
                    m_valid[idx_of(m_base)] = 1;
                    m_line[idx_of(m_base)]  = m_base;
                    m_busy = 0;
                end
            end
        end else if (!m_hit(p)) begin
            m_busy  = 1;
            m_base  = line_of(p);
            m_words = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model, advance.
    task automatic step(input bit r, input bit f, input logic [31:0] p, input bit a);
        bit h;
        reset = r; flush = f; pc = p; mem_ack = a;
        #1;
        if (m_known) begin
            h = m_hit(p);
            chk("model_stall", {31'b0, stall}, {31'b0, !h});
            chk("model_instr", instr, h ? (p & ~32'h3) : 32'h0);
            chk("model_req", {31'b0, mem_req}, {31'b0, m_busy});
            chk("model_addr", mem_addr, m_busy ? (m_base + 32'(m_words) * 4) : 32'h0);
        end
        m_update(r, f, p, a);
        @(posedge clk);
        #1;
    endtask

    // Explicit expectation for the current cycle, without advancing the clock.
    task automatic look(input logic [31:0] p, input bit e_stall, input logic [31:0] e_instr,
                        input bit e_req, input logic [31:0] e_addr);
        reset = 0; flush = 0; pc = p; mem_ack = 0;
        #1;
        chk("look_stall", {31'b0, stall}, {31'b0, e_stall});
        chk("look_instr", instr, e_instr);
        chk("look_req", {31'b0, mem_req}, {31'b0, e_req});
        chk("look_addr", mem_addr, e_addr);
    endtask

    // Acknowledge every 'period'-th cycle until 'stop' words arrived or refill ended.
    task automatic run_refill(input logic [31:0] p, input int period, input int stop);
        int  acks = 0;
        int  k    = 0;
        bit  a;
        while (m_busy && acks < stop && k < 200) begin
            a = ((k % period) == period - 1);
            if (a) acks++;
            step(0, 0, p, a);
            k++;
        end
        n_tests++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL refill_bound: %0d acks after %0d cycles, needed %0d", acks, k, stop);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          fl;
        logic [31:0] pc;
        bit          ack;
        bit          chk;
        bit          stall;
        logic [31:0] instr;
        bit          req;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit r, input bit f, input logic [31:0] p, input bit a,
                                input bit c, input bit s, input logic [31:0] i,
                                input bit q, input logic [31:0] d);
        vec_t v;
        v = '{rst: r, fl: f, pc: p, ack: a, chk: c, stall: s, instr: i, req: q, addr: d};
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; flush = 0; pc = 0; mem_ack = 0;

        // Zero-wait refill, conflict eviction, flush on a hit, reset mid-refill.
        add(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
        add(1, 0, 32'h100, 0, 1, 1, 0, 0, 0);
        add(0, 0, 32'h100, 1, 1, 1, 0, 0, 0);
        add(0, 0, 32'h100, 1, 1, 1, 0, 1, 32'h100);
        add(0, 0, 32'h100, 1, 1, 1, 0, 1, 32'h104);
        add(0, 0, 32'h100, 1, 1, 1, 0, 1, 32'h108);
        add(0, 0, 32'h100, 1, 1, 1, 0, 1, 32'h10C);
        add(0, 0, 32'h100, 1, 1, 0, 32'h100, 0, 0);
        add(0, 0, 32'h10C, 0, 1, 0, 32'h10C, 0, 0);
        add(0, 0, 32'h000, 1, 1, 1, 0, 0, 0);
        add(0, 0, 32'h000, 1, 1, 1, 0, 1, 32'h000);
        add(0, 0, 32'h000, 1, 1, 1, 0, 1, 32'h004);
        add(0, 0, 32'h000, 1, 1, 1, 0, 1, 32'h008);
        add(0, 0, 32'h000, 1, 1, 1, 0, 1, 32'h00C);
        add(0, 0, 32'h004, 0, 1, 0, 32'h004, 0, 0);
        add(0, 0, 32'h104, 1, 1, 1, 0, 0, 0);
        add(0, 0, 32'h104, 1, 1, 1, 0, 1, 32'h100);
        add(0, 0, 32'h104, 1, 1, 1, 0, 1, 32'h104);
        add(0, 0, 32'h104, 1, 1, 1, 0, 1, 32'h108);
        add(0, 0, 32'h104, 1, 1, 1, 0, 1, 32'h10C);
        add(0, 1, 32'h104, 0, 1, 0, 32'h104, 0, 0);
        add(0, 0, 32'h104, 1, 1, 1, 0, 0, 0);
        add(0, 0, 32'h104, 0, 1, 1, 0, 1, 32'h100);
        add(0, 0, 32'h104, 0, 1, 1, 0, 1, 32'h100);
        add(1, 0, 32'h104, 1, 1, 1, 0, 1, 32'h100);
        add(0, 0, 32'h104, 0, 1, 1, 0, 0, 0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            reset = vecs[i].rst; flush = vecs[i].fl; pc = vecs[i].pc; mem_ack = vecs[i].ack;
            #1;
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].stall});
                chk($sformatf("vec%0d_instr", i), instr, vecs[i].instr);
                chk($sformatf("vec%0d_req", i), {31'b0, mem_req}, {31'b0, vecs[i].req});
                chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
            end
            m_update(vecs[i].rst, vecs[i].fl, vecs[i].pc, vecs[i].ack);
            @(posedge clk);
            #1;
        end

        // Cold miss, memory acks every third cycle.
        step(1, 0, 32'h0040_0000, 0);
        step(0, 0, 32'h0040_0000, 0);
        run_refill(32'h0040_0000, 3, 4);
        look(32'h0040_0000, 0, 32'h0040_0000, 0, 0);
        step(0, 0, 32'h0040_0000, 0);
        look(32'h0040_0008, 0, 32'h0040_0008, 0, 0);
        step(0, 0, 32'h0040_0008, 0);

        // Flush after the second word aborts the refill; it restarts at word 0.
        step(1, 0, 32'h500, 0);
        step(0, 0, 32'h500, 0);
        run_refill(32'h500, 2, 2);
        step(0, 1, 32'h500, 0);
        look(32'h500, 1, 0, 0, 0);
        step(0, 0, 32'h500, 0);
        look(32'h500, 1, 0, 1, 32'h500);
        run_refill(32'h500, 1, 4);
        look(32'h504, 0, 32'h504, 0, 0);
        step(0, 0, 32'h504, 0);

        // Flush together with the final word: line stays invalid.
        step(0, 0, 32'h580, 0);
        run_refill(32'h580, 1, 3);
        step(0, 1, 32'h580, 1);
        look(32'h580, 1, 0, 0, 0);
        step(0, 0, 32'h580, 0);
        run_refill(32'h580, 1, 4);

        // Reset after the first word of a refill.
        step(1, 0, 32'h600, 0);
        step(0, 0, 32'h600, 0);
        run_refill(32'h600, 1, 4);
        look(32'h600, 0, 32'h600, 0, 0);
        step(0, 0, 32'h740, 0);
        run_refill(32'h740, 2, 1);
        step(1, 0, 32'h740, 0);
        look(32'h740, 1, 0, 0, 0);
        look(32'h600, 1, 0, 0, 0);
        step(0, 0, 32'h600, 0);
        run_refill(32'h600, 1, 4);

        // pc moves away mid-refill; the latched line still completes.
        step(1, 0, 32'h200, 0);
        step(0, 0, 32'h200, 0);
        run_refill(32'h200, 2, 2);
        run_refill(32'h310, 1, 2);
        look(32'h310, 1, 0, 0, 0);
        step(0, 0, 32'h310, 0);
        run_refill(32'h310, 2, 4);
        look(32'h310, 0, 32'h310, 0, 0);
        look(32'h20C, 0, 32'h20C, 0, 0);
        step(0, 0, 32'h20C, 0);

        // Randomized traffic with conflicting tags, random acks, flushes and resets.
        begin
            logic [31:0] rp;
            rp = 32'h0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 9) < 3)
                    rp = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 63)) << 2)
                         | 32'($urandom_range(0, 3));
                step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0, rp,
                     $urandom_range(0, 1) == 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
